// File: rtl/control_sequencer.sv
// Microcode control sequencer for the 8-bit bus computer.
// Holds the T-state step counter and the halt latch. It decodes opcode, step
// and flags combinationally into the 16-bit control word.
module control_sequencer #(
  parameter int NUM_STEPS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode,
  input  logic        carry_flag,
  input  logic        zero_flag,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        halted
);

  // Control word bit positions
  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic [2:0] step_q;
  logic [2:0] step_d;
  logic       halted_q;
  logic       halted_d;
  logic [15:0] micro_s;

  // Microcode ROM: fetch at T0/T1, execute at T2..T4, idle beyond T4.
  // Flags are consulted only at T2, so a flag change at any other step has no effect.
  function automatic logic [15:0] micro_word(
    input logic [2:0] t,
    input logic [3:0] op,
    input logic       c,
    input logic       z
  );
    logic [15:0] w;
    w = 16'h0000;
    case (t)
      3'd0: w = C_CO | C_MI;
      3'd1: w = C_RO | C_II | C_CE;
      3'd2: begin
        case (op)
          OP_NOP: w = 16'h0000;
          OP_LDA: w = C_IO | C_MI;
          OP_ADD: w = C_IO | C_MI;
          OP_SUB: w = C_IO | C_MI;
          OP_STA: w = C_IO | C_MI;
          OP_LDI: w = C_IO | C_AI;
          OP_JMP: w = C_IO | C_J;
          OP_JC:  w = c ? (C_IO | C_J) : 16'h0000;
          OP_JZ:  w = z ? (C_IO | C_J) : 16'h0000;
          OP_OUT: w = C_AO | C_OI;
          OP_HLT: w = C_HLT;
          default: w = 16'h0000;
        endcase
      end
      3'd3: begin
        case (op)
          OP_LDA: w = C_RO | C_AI;
          OP_ADD: w = C_RO | C_BI;
          OP_SUB: w = C_RO | C_BI;
          OP_STA: w = C_AO | C_RI;
          default: w = 16'h0000;
        endcase
      end
      3'd4: begin
        case (op)
          OP_ADD: w = C_EO | C_AI | C_FI;
          OP_SUB: w = C_EO | C_AI | C_SU | C_FI;
          default: w = 16'h0000;
        endcase
      end
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  // Next-state logic for the step counter and halt latch. Reset wins over halt entry.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (rst) begin
      step_d   = 3'd0;
      halted_d = 1'b0;
    end else if (halted_q) begin
      step_d   = step_q;
      halted_d = 1'b1;
    end else begin
      if (step_q == LAST_STEP) begin
        step_d = 3'd0;
      end else begin
        step_d = step_q + 3'd1;
      end
      if ((step_q == 3'd2) && (opcode == OP_HLT)) begin
        halted_d = 1'b1;
      end else begin
        halted_d = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    step_q   <= step_d;
    halted_q <= halted_d;
  end

  // The control word is combinational, so each strobe is valid before the edge that consumes it.
  always_comb begin
    micro_s = micro_word(step_q, opcode, carry_flag, zero_flag);
    if (rst) begin
      ctrl = 16'h0000;
    end else if (halted_q) begin
      ctrl = C_HLT;
    end else begin
      ctrl = micro_s;
    end
  end

  assign step   = step_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer. Two instances run side by side: NUM_STEPS=5 and NUM_STEPS=6.
// A behavioural model predicts every output on every cycle. Directed literal
// checks pin both the model and the DUT at key points.
module tb_control_sequencer;

  logic        clk;
  logic        rst;
  logic [3:0]  opcode;
  logic        carry_flag;
  logic        zero_flag;
  logic [15:0] ctrl5, ctrl6;
  logic [2:0]  step5, step6;
  logic        halted5, halted6;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  // Model state, one entry per instance
  int m_step [2];
  bit m_halt [2];
  int m_n    [2];

  control_sequencer #(.NUM_STEPS(5)) dut5 (
    .clk(clk), .rst(rst), .opcode(opcode), .carry_flag(carry_flag),
    .zero_flag(zero_flag), .ctrl(ctrl5), .step(step5), .halted(halted5)
  );

  control_sequencer #(.NUM_STEPS(6)) dut6 (
    .clk(clk), .rst(rst), .opcode(opcode), .carry_flag(carry_flag),
    .zero_flag(zero_flag), .ctrl(ctrl6), .step(step6), .halted(halted6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word from the instruction table, by mnemonic
  function automatic logic [15:0] model_ctrl(int idx);
    logic [15:0] w;
    int t;
    w = 16'h0000;
    t = m_step[idx];
    if (rst) return 16'h0000;
    if (m_halt[idx]) return 16'h8000;
    if (t == 0) return 16'h4000 + 16'h0004;             // MI + CO
    if (t == 1) return 16'h1000 + 16'h0400 + 16'h0008;  // RO + II + CE
    case (opcode)
      4'd1: begin
        if (t == 2) w = 16'h0800 + 16'h4000;
        if (t == 3) w = 16'h1000 + 16'h0200;
      end
      4'd2, 4'd3: begin
        if (t == 2) w = 16'h0800 + 16'h4000;
        if (t == 3) w = 16'h1000 + 16'h0020;
        if (t == 4) w = 16'h0080 + 16'h0200 + 16'h0001 + ((opcode == 4'd3) ? 16'h0040 : 16'h0000);
      end
      4'd4: begin
        if (t == 2) w = 16'h0800 + 16'h4000;
        if (t == 3) w = 16'h0100 + 16'h2000;
      end
      4'd5: if (t == 2) w = 16'h0800 + 16'h0200;
      4'd6: if (t == 2) w = 16'h0800 + 16'h0002;
      4'd7: if (t == 2 && carry_flag) w = 16'h0800 + 16'h0002;
      4'd8: if (t == 2 && zero_flag) w = 16'h0800 + 16'h0002;
      4'd14: if (t == 2) w = 16'h0100 + 16'h0010;
      4'd15: if (t == 2) w = 16'h8000;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  // Model update at each rising edge
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_step[i] = 0;
        m_halt[i] = 1'b0;
      end else if (!m_halt[i]) begin
        if (m_step[i] == 2 && opcode == 4'd15) m_halt[i] = 1'b1;
        m_step[i] = (m_step[i] + 1) % m_n[i];
      end
    end
  end

  task automatic cmp(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (armed) begin
      cmp("m5.ctrl", ctrl5, model_ctrl(0));
      cmp("m5.step", {13'd0, step5}, 16'(m_step[0]));
      cmp("m5.halted", {15'd0, halted5}, {15'd0, m_halt[0]});
      cmp("m6.ctrl", ctrl6, model_ctrl(1));
      cmp("m6.step", {13'd0, step6}, 16'(m_step[1]));
      cmp("m6.halted", {15'd0, halted6}, {15'd0, m_halt[1]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    m_n[0] = 5;
    m_n[1] = 6;
    m_step[0] = 0; m_step[1] = 0;
    m_halt[0] = 1'b0; m_halt[1] = 1'b0;
    rst = 1'b1; opcode = 4'b0010; carry_flag = 1'b0; zero_flag = 1'b0;

    // Reset hold for three cycles
    tick();
    armed = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cmp("rst.ctrl5", ctrl5, 16'h0000);
      cmp("rst.ctrl6", ctrl6, 16'h0000);
      if (k < 2) tick();
    end
    tick();
    rst = 1'b0;

    // ADD full cycle and wrap
    @(negedge clk); cmp("add.step0", {13'd0, step5}, 16'd0); cmp("add.t0", ctrl5, 16'h4004);
    tick(); @(negedge clk); cmp("add.t1", ctrl5, 16'h1408);
    tick(); @(negedge clk); cmp("add.t2", ctrl5, 16'h4800);
    tick(); @(negedge clk); cmp("add.t3", ctrl5, 16'h1020);
    tick(); @(negedge clk); cmp("add.t4", ctrl5, 16'h0281);
    tick(); @(negedge clk); cmp("add.wrap", {13'd0, step5}, 16'd0); cmp("add.wrap.ctrl", ctrl5, 16'h4004);
    cmp("add.m6.t5", ctrl6, 16'h0000);

    // Conditional jumps, each flag value
    do_reset(); opcode = 4'b0111; carry_flag = 1'b0; ticks(2);
    @(negedge clk); cmp("jc.c0", ctrl5, 16'h0000);
    do_reset(); carry_flag = 1'b1; ticks(2);
    @(negedge clk); cmp("jc.c1", ctrl5, 16'h0802);
    tick(); carry_flag = 1'b0; @(negedge clk); cmp("jc.t3", ctrl5, 16'h0000);
    do_reset(); opcode = 4'b1000; zero_flag = 1'b0; ticks(2);
    @(negedge clk); cmp("jz.z0", ctrl5, 16'h0000);
    do_reset(); zero_flag = 1'b1; ticks(2);
    @(negedge clk); cmp("jz.z1", ctrl5, 16'h0802);
    zero_flag = 1'b0;

    // Reset in the middle of SUB
    do_reset(); opcode = 4'b0011; ticks(3);
    @(negedge clk); cmp("sub.t3", ctrl5, 16'h1020);
    tick(); @(negedge clk); cmp("sub.t4", ctrl5, 16'h02C1);
    do_reset(); ticks(3); rst = 1'b1;
    @(negedge clk); cmp("sub.rst.ctrl", ctrl5, 16'h0000);
    tick(); rst = 1'b0;
    @(negedge clk); cmp("sub.rst.step", {13'd0, step5}, 16'd0); cmp("sub.rst.t0", ctrl5, 16'h4004);

    // Undefined opcode executes as NOP; STA/LDA/OUT spot values
    do_reset(); opcode = 4'b1010; ticks(2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); cmp("undef.t", ctrl5, 16'h0000);
      tick();
    end
    do_reset(); opcode = 4'b0100; ticks(3); @(negedge clk); cmp("sta.t3", ctrl5, 16'h2100);
    do_reset(); opcode = 4'b0001; ticks(3); @(negedge clk); cmp("lda.t3", ctrl5, 16'h1200);
    do_reset(); opcode = 4'b1110; ticks(2); @(negedge clk); cmp("out.t2", ctrl5, 16'h0110);

    // NUM_STEPS=6 instance running LDI
    do_reset(); opcode = 4'b0101; ticks(2);
    @(negedge clk); cmp("ldi6.t2", ctrl6, 16'h0A00);
    for (int k = 3; k <= 5; k++) begin
      tick(); @(negedge clk); cmp("ldi6.tail", ctrl6, 16'h0000);
    end
    cmp("ldi6.step5", {13'd0, step6}, 16'd5);
    tick(); @(negedge clk); cmp("ldi6.wrap", {13'd0, step6}, 16'd0);

    // Reset wins over halt entry on the same edge
    do_reset(); opcode = 4'b1111; ticks(2); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk); cmp("hlt.rstprio", {15'd0, halted5}, 16'd0);

    // Halt entry, hold, and release by reset
    do_reset(); ticks(2);
    @(negedge clk); cmp("hlt.t2", ctrl5, 16'h8000); cmp("hlt.pre", {15'd0, halted5}, 16'd0);
    tick(); opcode = 4'b0010; carry_flag = 1'b1;
    @(negedge clk); cmp("hlt.latched", {15'd0, halted5}, 16'd1);
    cmp("hlt.step", {13'd0, step5}, 16'd3);
    ticks(12);
    @(negedge clk); cmp("hlt.hold.step", {13'd0, step5}, 16'd3); cmp("hlt.hold.ctrl", ctrl5, 16'h8000);
    cmp("hlt.hold.ctrl6", ctrl6, 16'h8000);
    do_reset();
    @(negedge clk); cmp("hlt.clr", {15'd0, halted5}, 16'd0);
    cmp("hlt.clr.step", {13'd0, step5}, 16'd0); cmp("hlt.clr.ctrl", ctrl5, 16'h4004);
    tick(); @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
